bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter_if.sv | 49 ++++
 rtl/bus_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_bus_rr_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_rr_arbiter_if.sv
// Requester and bus-side signal bundle for the three-port bus arbiter.
// master is the arbiter's view; slave is the environment's view.
interface bus_rr_arbiter_if;
    logic [31:0] addr_0;
    logic [31:0] addr_1;
    logic [31:0] addr_2;
    logic [31:0] data_0;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic        we_0;
    logic        we_1;
    logic        we_2;
    logic        start_0;
    logic        start_1;
    logic        start_2;
    logic        done_0;
    logic        done_1;
    logic        done_2;
    logic [31:0] q;
    logic        err;
    logic [26:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_we;
    logic        bus_start;
    logic [31:0] bus_q;
    logic        bus_done;

    modport master (
        input  addr_0, addr_1, addr_2,
        input  data_0, data_1, data_2,
        input  we_0, we_1, we_2,
        input  start_0, start_1, start_2,
        output done_0, done_1, done_2,
        output q, err,
        output bus_addr, bus_data, bus_we, bus_start,
        input  bus_q, bus_done
    );

    modport slave (
        output addr_0, addr_1, addr_2,
        output data_0, data_1, data_2,
        output we_0, we_1, we_2,
        output start_0, start_1, start_2,
        input  done_0, done_1, done_2,
        input  q, err,
        input  bus_addr, bus_data, bus_we, bus_start,
        output bus_q, bus_done
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Three-requester bus arbiter (instr, data, DMA) with round-robin or
// fixed priority selection and a bus-wait watchdog.
module bus_rr_arbiter #(
    parameter int TIMEOUT    = 1023,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic clk,
    input  logic reset,
    bus_rr_arbiter_if.master io
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit        WD_ON = (TIMEOUT != 0);
    localparam logic [9:0] TMAX = 10'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  gnt;
    logic [1:0]  last;
    logic [1:0]  sel;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [9:0]  cnt;
    logic [3:0]  req;
    logic        any;
    logic        busy;
    logic        hit;
    logic        fin;
    logic        grant;
    logic [26:0] addr_sel;
    logic [31:0] data_sel;
    logic        we_sel;
    logic [26:0] addr_r;
    logic [31:0] data_r;
    logic        we_r;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // req[3] is a constant pad so a 2-bit pointer never indexes out of range
    assign req   = {1'b0, io.start_2, io.start_1, io.start_0};
    assign any   = |req;
    assign c0    = nxt(last);
    assign c1    = nxt(c0);
    assign busy  = (state == BUSY);
    assign grant = (state == IDLE) && any;
    assign hit   = WD_ON && busy && (cnt == TMAX) && !io.bus_done;
    assign fin   = busy && (io.bus_done || hit);

    always_comb begin
        sel = last;
        if (FIXED_PRIO) begin
            if (req[1])
                sel = 2'd1;
            else if (req[0])
                sel = 2'd0;
            else
                sel = 2'd2;
        end else begin
            if (req[c0])
                sel = c0;
            else if (req[c1])
                sel = c1;
            else
                sel = last;
        end
    end

    always_comb begin
        addr_sel = io.addr_2[26:0];
        data_sel = io.data_2;
        we_sel   = io.we_2;
        case (sel)
            2'd0: begin
                addr_sel = io.addr_0[26:0];
                data_sel = io.data_0;
                we_sel   = io.we_0;
            end
            2'd1: begin
                addr_sel = io.addr_1[26:0];
                data_sel = io.data_1;
                we_sel   = io.we_1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // BUSY always exits to IDLE, so back-to-back grants are two cycles apart
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (any) state_nxt = BUSY;
            BUSY: if (fin) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt    <= 2'd0;
            last   <= 2'd2;
            cnt    <= 10'd0;
            addr_r <= 27'd0;
            data_r <= 32'd0;
            we_r   <= 1'b0;
        end else if (grant) begin
            gnt    <= sel;
            last   <= sel;
            cnt    <= 10'd0;
            addr_r <= addr_sel;
            data_r <= data_sel;
            we_r   <= we_sel;
        end else if (busy) begin
            cnt <= cnt + 10'd1;
        end
    end

    assign io.bus_addr  = addr_r;
    assign io.bus_data  = data_r;
    assign io.bus_we    = we_r;
    assign io.bus_start = busy && !io.bus_done;
    assign io.done_0    = fin && (gnt == 2'd0);
    assign io.done_1    = fin && (gnt == 2'd1);
    assign io.done_2    = fin && (gnt == 2'd2);
    assign io.q         = hit ? 32'h0 : io.bus_q;
    assign io.err       = hit;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: round-robin, fixed-priority and watchdog
// instances driven from vector tables plus a done-pulse scoreboard.
module tb_bus_rr_arbiter;

    typedef struct {
        int          d;
        logic [1:0]  port;
        logic [31:0] q;
        logic        err;
        logic [26:0] addr;
        logic [31:0] data;
        logic        we;
    } exp_t;

    typedef struct {
        logic [2:0]  req;
        int          lat;
        logic [1:0]  port;
        logic [31:0] bq;
    } vec_t;

    logic clk;
    logic rst_n;

    logic [31:0] addr_v [3][3];
    logic [31:0] data_v [3][3];
    logic        we_v   [3][3];
    logic [2:0]  st     [3];
    logic [31:0] bq     [3];
    int          lat    [3];
    logic        fbd    [3];

    logic [2:0]  dn  [3];
    logic [31:0] qv  [3];
    logic [31:0] bdv [3];
    logic [26:0] bav [3];
    logic        ev  [3];
    logic        bsv [3];
    logic        bwv [3];

    exp_t sb [$];
    exp_t me;
    vec_t tbl [8];
    int   checks = 0;
    int   errors = 0;

    bus_rr_arbiter_if ifc [3] ();

    bus_rr_arbiter #(.TIMEOUT(1023), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .reset(rst_n), .io(ifc[0])
    );
    bus_rr_arbiter #(.TIMEOUT(1023), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(rst_n), .io(ifc[1])
    );
    bus_rr_arbiter #(.TIMEOUT(4), .FIXED_PRIO(1'b0)) dut_to (
        .clk(clk), .reset(rst_n), .io(ifc[2])
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_env
        logic bdone = 1'b0;
        int   bc    = 0;
        assign ifc[g].addr_0   = addr_v[g][0];
        assign ifc[g].addr_1   = addr_v[g][1];
        assign ifc[g].addr_2   = addr_v[g][2];
        assign ifc[g].data_0   = data_v[g][0];
        assign ifc[g].data_1   = data_v[g][1];
        assign ifc[g].data_2   = data_v[g][2];
        assign ifc[g].we_0     = we_v[g][0];
        assign ifc[g].we_1     = we_v[g][1];
        assign ifc[g].we_2     = we_v[g][2];
        assign ifc[g].start_0  = st[g][0];
        assign ifc[g].start_1  = st[g][1];
        assign ifc[g].start_2  = st[g][2];
        assign ifc[g].bus_q    = bq[g];
        assign ifc[g].bus_done = bdone | fbd[g];
        assign dn[g]  = {ifc[g].done_2, ifc[g].done_1, ifc[g].done_0};
        assign qv[g]  = ifc[g].q;
        assign ev[g]  = ifc[g].err;
        assign bav[g] = ifc[g].bus_addr;
        assign bdv[g] = ifc[g].bus_data;
        assign bwv[g] = ifc[g].bus_we;
        assign bsv[g] = ifc[g].bus_start;

        // bus model: completes in the lat-th BUSY cycle, never if lat is 0
        always @(negedge clk) begin
            bdone = 1'b0;
            #1;
            if (bsv[g]) begin
                bc++;
                if (bc == lat[g])
                    bdone = 1'b1;
            end else begin
                bc = 0;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void push(int d, int p, logic [31:0] q, logic e);
        exp_t x;
        x.d    = d;
        x.port = 2'(p);
        x.q    = q;
        x.err  = e;
        x.addr = addr_v[d][p][26:0];
        x.data = data_v[d][p];
        x.we   = we_v[d][p];
        sb.push_back(x);
    endfunction

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic run_one(int d, int maxc, output int nbs);
        bit ok;
        nbs = 0;
        ok  = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            cyc();
            if (bsv[d]) nbs++;
            if (dn[d] != 3'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 3; d++) begin
            if (dn[d] != 3'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut %0d got %b want none",
                             d, dn[d]);
                end else begin
                    me = sb.pop_front();
                    chk("sb_dut", 32'(d), 32'(me.d));
                    chk("sb_port", 32'(dn[d]), 32'(3'b001 << me.port));
                    chk("sb_q", qv[d], me.q);
                    chk("sb_err", 32'(ev[d]), 32'(me.err));
                    chk("sb_addr", 32'(bav[d]), 32'(me.addr));
                    chk("sb_data", bdv[d], me.data);
                    chk("sb_we", 32'(bwv[d]), 32'(me.we));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbs;
        int nd;
        int last_t;

        tbl[0] = '{3'b111, 1, 2'd1, 32'hA000_0001};
        tbl[1] = '{3'b101, 2, 2'd2, 32'hA000_0002};
        tbl[2] = '{3'b011, 3, 2'd0, 32'hA000_0003};
        tbl[3] = '{3'b101, 5, 2'd2, 32'hA000_0004};
        tbl[4] = '{3'b110, 1, 2'd1, 32'hA000_0005};
        tbl[5] = '{3'b001, 4, 2'd0, 32'hA000_0006};
        tbl[6] = '{3'b100, 2, 2'd2, 32'hA000_0007};
        tbl[7] = '{3'b010, 6, 2'd1, 32'hA000_0008};

        clk   = 1'b0;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            st[d]  = 3'b0;
            bq[d]  = 32'h0;
            lat[d] = 0;
            fbd[d] = 1'b0;
            for (int n = 0; n < 3; n++) begin
                addr_v[d][n] = 32'h0;
                data_v[d][n] = 32'h0;
                we_v[d][n]   = 1'b0;
            end
        end
        cyc();
        cyc();

        for (int d = 0; d < 3; d++) begin
            chk("rst_bus_start", 32'(bsv[d]), 32'd0);
            chk("rst_done", 32'(dn[d]), 32'd0);
            chk("rst_err", 32'(ev[d]), 32'd0);
            chk("rst_bus_addr", 32'(bav[d]), 32'd0);
            chk("rst_bus_data", bdv[d], 32'd0);
            chk("rst_bus_we", 32'(bwv[d]), 32'd0);
        end
        rst_n = 1'b1;
        cyc();

        // all three held, round-robin, one bus_start cycle per access
        for (int n = 0; n < 3; n++) begin
            addr_v[0][n] = 32'h1000_0000 + 32'(n);
            data_v[0][n] = 32'h2000_0000 + 32'(n);
            we_v[0][n]   = n[0];
        end
        bq[0]  = 32'h0000_0035;
        lat[0] = 2;
        st[0]  = 3'b111;
        push(0, 0, bq[0], 1'b0);
        push(0, 1, bq[0], 1'b0);
        push(0, 2, bq[0], 1'b0);
        push(0, 0, bq[0], 1'b0);
        nd = 0;
        last_t = 0;
        for (int c = 0; c < 40 && nd < 4; c++) begin
            cyc();
            if (dn[0] != 3'b0) begin
                if (nd > 0) chk("rr_spacing", 32'(c - last_t), 32'd3);
                last_t = c;
                nd++;
                if (nd == 4) st[0] = 3'b0;
            end
        end
        chk("rr_count", 32'(nd), 32'd4);

        for (int i = 0; i < 8; i++) begin
            for (int n = 0; n < 3; n++) begin
                addr_v[0][n] = 32'h8000_0000 | 32'(i << 8) | 32'(n);
                data_v[0][n] = ~addr_v[0][n];
                we_v[0][n]   = 1'((i + n) % 2);
            end
            bq[0]  = tbl[i].bq;
            lat[0] = tbl[i].lat;
            st[0]  = tbl[i].req;
            push(0, int'(tbl[i].port), tbl[i].bq, 1'b0);
            run_one(0, 20, nbs);
            chk("tbl_bus_start", 32'(nbs), 32'(tbl[i].lat - 1));
        end
        st[0] = 3'b0;
        cyc();

        // single data-port read, three bus_start cycles
        addr_v[0][1] = 32'hF000_0010;
        data_v[0][1] = 32'h5555_AAAA;
        we_v[0][1]   = 1'b0;
        bq[0]  = 32'hDEAD_BEEF;
        lat[0] = 4;
        st[0]  = 3'b010;
        push(0, 1, 32'hDEAD_BEEF, 1'b0);
        run_one(0, 20, nbs);
        chk("r34_bus_start", 32'(nbs), 32'd3);
        chk("r34_addr", 32'(bav[0]), 32'h0000_0010);
        chk("r34_q", qv[0], 32'hDEAD_BEEF);
        st[0] = 3'b0;
        cyc();

        // fixed priority, each requester drops start after its done
        for (int n = 0; n < 3; n++) begin
            addr_v[1][n] = 32'h3000_0000 + 32'(n);
            data_v[1][n] = 32'h4000_0000 + 32'(n);
            we_v[1][n]   = 1'b1;
        end
        bq[1]  = 32'h0000_0036;
        lat[1] = 2;
        st[1]  = 3'b111;
        push(1, 1, bq[1], 1'b0);
        push(1, 0, bq[1], 1'b0);
        push(1, 2, bq[1], 1'b0);
        nd = 0;
        for (int c = 0; c < 40 && nd < 3; c++) begin
            cyc();
            if (dn[1] != 3'b0) begin
                st[1] = st[1] & ~dn[1];
                nd++;
            end
        end
        chk("fp_count", 32'(nd), 32'd3);
        cyc();

        // watchdog expiry with a silent bus
        for (int n = 0; n < 3; n++) begin
            addr_v[2][n] = 32'h5000_0000 + 32'(n);
            data_v[2][n] = 32'h6000_0000 + 32'(n);
            we_v[2][n]   = 1'b0;
        end
        bq[2]  = 32'h1234_5678;
        lat[2] = 0;
        st[2]  = 3'b100;
        push(2, 2, 32'h0, 1'b1);
        run_one(2, 20, nbs);
        chk("to_busy_cycles", 32'(nbs), 32'd4);
        chk("to_err", 32'(ev[2]), 32'd1);
        chk("to_q", qv[2], 32'h0);
        st[2] = 3'b0;
        cyc();
        chk("to_idle_bus_start", 32'(bsv[2]), 32'd0);

        // bus_done in the would-be timeout cycle completes normally
        bq[2]  = 32'hCAFE_0004;
        lat[2] = 4;
        st[2]  = 3'b001;
        push(2, 0, 32'hCAFE_0004, 1'b0);
        run_one(2, 20, nbs);
        chk("race_bus_start", 32'(nbs), 32'd3);
        chk("race_err", 32'(ev[2]), 32'd0);
        st[2] = 3'b0;
        cyc();

        // reset aborts a transaction on port 1; stray bus_done is ignored
        lat[0] = 0;
        bq[0]  = 32'h0000_0039;
        st[0]  = 3'b010;
        cyc();
        chk("abort_busy", 32'(bsv[0]), 32'd1);
        cyc();
        rst_n = 1'b0;
        st[0] = 3'b0;
        #1;
        chk("abort_bus_start", 32'(bsv[0]), 32'd0);
        chk("abort_done", 32'(dn[0]), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        fbd[0] = 1'b1;
        #1;
        chk("stray_done", 32'(dn[0]), 32'd0);
        chk("stray_bus_start", 32'(bsv[0]), 32'd0);
        cyc();
        fbd[0] = 1'b0;
        chk("stray_after", 32'(bsv[0]), 32'd0);
        lat[0] = 2;
        st[0]  = 3'b111;
        push(0, 0, bq[0], 1'b0);
        run_one(0, 20, nbs);
        st[0] = 3'b0;
        cyc();
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
